// File: rtl/song_sequencer.sv
// Rhythm-game playback controller. It divides the system clock down to beat
// ticks, runs an optional count-in, then steps through the song beats.
// Pause/resume and abort are supported, and a level finish flag is raised
// once the last beat has played.
module song_sequencer #(
    parameter int unsigned BEAT_DIV   = 6000000,
    parameter int unsigned SONG_BEATS = 64,
    parameter int unsigned COUNT_IN   = 4,
    localparam int unsigned DIV_W     = $clog2(BEAT_DIV),
    localparam int unsigned CL_W      = (COUNT_IN > 0) ? $clog2(COUNT_IN + 1) : 1,
    localparam int unsigned IDX_W     = (SONG_BEATS > 1) ? $clog2(SONG_BEATS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic             count_pulse,
    output logic [CL_W-1:0]  count_left,
    output logic             beat_pulse,
    output logic [IDX_W-1:0] beat_idx,
    output logic             playing,
    output logic             paused,
    output logic             finish
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEAT_DIV - 1);
    localparam logic [CL_W-1:0]  CL_INIT  = CL_W'(COUNT_IN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SONG_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COUNTIN = 3'd1,
        PLAY    = 3'd2,
        PAUSE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CL_W-1:0]   count_left_q, count_left_d;
    logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
    // Set once the first song beat has played; the first beat keeps index 0.
    logic              beat_seen_q, beat_seen_d;
    logic              count_pulse_q, count_pulse_d;
    logic              beat_pulse_q, beat_pulse_d;
    logic              playing_q, playing_d;
    logic              paused_q, paused_d;
    logic              finish_q, finish_d;
    logic              tick;

    // Next-state and next-output logic; abort outranks pause, pause outranks tick.
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        count_left_d  = count_left_q;
        beat_idx_d    = beat_idx_q;
        beat_seen_d   = beat_seen_q;
        count_pulse_d = 1'b0;
        beat_pulse_d  = 1'b0;
        tick          = 1'b0;

        if (abort) begin
            state_d      = IDLE;
            div_d        = '0;
            count_left_d = '0;
            beat_idx_d   = '0;
            beat_seen_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    div_d = '0;
                    if (start) begin
                        beat_idx_d  = '0;
                        beat_seen_d = 1'b0;
                        if (COUNT_IN == 0) begin
                            state_d = PLAY;
                        end else begin
                            state_d      = COUNTIN;
                            count_left_d = CL_INIT;
                        end
                    end
                end
                COUNTIN: begin
                    tick  = (div_q == DIV_LAST);
                    div_d = tick ? '0 : div_q + DIV_W'(1);
                    if (tick) begin
                        count_pulse_d = 1'b1;
                        count_left_d  = count_left_q - CL_W'(1);
                        if (count_left_q == CL_W'(1)) begin
                            state_d     = PLAY;
                            beat_idx_d  = '0;
                            beat_seen_d = 1'b0;
                        end
                    end
                end
                PLAY: begin
                    if (pause) begin
                        // Prescaler freezes so a suppressed tick fires right after resume.
                        state_d = PAUSE;
                    end else begin
                        tick  = (div_q == DIV_LAST);
                        div_d = tick ? '0 : div_q + DIV_W'(1);
                        if (tick) begin
                            beat_pulse_d = 1'b1;
                            beat_seen_d  = 1'b1;
                            if (beat_seen_q) begin
                                beat_idx_d = beat_idx_q + IDX_W'(1);
                            end
                            if (beat_idx_d == IDX_LAST) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (pause) begin
                        state_d = PLAY;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        playing_d = (state_d == PLAY);
        paused_d  = (state_d == PAUSE);
        finish_d  = (state_d == DONE);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            div_q         <= '0;
            count_left_q  <= '0;
            beat_idx_q    <= '0;
            beat_seen_q   <= 1'b0;
            count_pulse_q <= 1'b0;
            beat_pulse_q  <= 1'b0;
            playing_q     <= 1'b0;
            paused_q      <= 1'b0;
            finish_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            count_left_q  <= count_left_d;
            beat_idx_q    <= beat_idx_d;
            beat_seen_q   <= beat_seen_d;
            count_pulse_q <= count_pulse_d;
            beat_pulse_q  <= beat_pulse_d;
            playing_q     <= playing_d;
            paused_q      <= paused_d;
            finish_q      <= finish_d;
        end
    end

    assign count_pulse = count_pulse_q;
    assign count_left  = count_left_q;
    assign beat_pulse  = beat_pulse_q;
    assign beat_idx    = beat_idx_q;
    assign playing     = playing_q;
    assign paused      = paused_q;
    assign finish      = finish_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: expected outputs per cycle come from a schedule
// model built on the beat-timing formulas (count-in pulses, beat cycles,
// pause shifts, abort/restart cut points).
module tb_song_sequencer;

    localparam int unsigned BD = 4;
    localparam int unsigned SB = 8;
    localparam int unsigned CI = 2;
    localparam int N = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic a_start, a_pause, a_abort;
    logic a_cp, a_bp, a_pl, a_pa, a_fi;
    logic [1:0] a_cl;
    logic [2:0] a_bi;
    logic b_start, b_pause, b_abort;
    logic b_cp, b_bp, b_pl, b_pa, b_fi;
    logic [0:0] b_cl;
    logic [0:0] b_bi;

    song_sequencer #(.BEAT_DIV(BD), .SONG_BEATS(SB), .COUNT_IN(CI)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .pause(a_pause), .abort(a_abort),
        .count_pulse(a_cp), .count_left(a_cl), .beat_pulse(a_bp), .beat_idx(a_bi),
        .playing(a_pl), .paused(a_pa), .finish(a_fi)
    );

    song_sequencer #(.BEAT_DIV(4), .SONG_BEATS(1), .COUNT_IN(0)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .pause(b_pause), .abort(b_abort),
        .count_pulse(b_cp), .count_left(b_cl), .beat_pulse(b_bp), .beat_idx(b_bi),
        .playing(b_pl), .paused(b_pa), .finish(b_fi)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int beats_seen;
    int cut;

    // Expected outputs per relative cycle, and input schedule per relative edge.
    int e_cp [N];
    int e_cl [N];
    int e_bp [N];
    int e_bi [N];
    int e_pl [N];
    int e_pa [N];
    int e_fi [N];
    bit s_start [N];
    bit s_pause [N];
    bit s_abort [N];

    task automatic check(input string tag, input bit sel, input int cyc,
                         input logic [31:0] obs, input int exp);
        n_checks++;
        assert (obs === 32'(exp)) n_pass++;
        else $error("FAIL %s dut=%0d cyc=%0d got=%0d expected=%0d", tag, sel, cyc, obs, exp);
    endtask

    task automatic check_vals(input bit sel, input int cyc, input int cp, input int cl,
                              input int bp, input int bi, input int pl, input int pa,
                              input int fi);
        logic [31:0] o_cp, o_cl, o_bp, o_bi, o_pl, o_pa, o_fi;
        if (sel) begin
            o_cp = 32'(b_cp); o_cl = 32'(b_cl); o_bp = 32'(b_bp); o_bi = 32'(b_bi);
            o_pl = 32'(b_pl); o_pa = 32'(b_pa); o_fi = 32'(b_fi);
        end else begin
            o_cp = 32'(a_cp); o_cl = 32'(a_cl); o_bp = 32'(a_bp); o_bi = 32'(a_bi);
            o_pl = 32'(a_pl); o_pa = 32'(a_pa); o_fi = 32'(a_fi);
        end
        if (o_bp === 32'd1) beats_seen++;
        check("count_pulse", sel, cyc, o_cp, cp);
        check("count_left",  sel, cyc, o_cl, cl);
        check("beat_pulse",  sel, cyc, o_bp, bp);
        check("beat_idx",    sel, cyc, o_bi, bi);
        check("playing",     sel, cyc, o_pl, pl);
        check("paused",      sel, cyc, o_pa, pa);
        check("finish",      sel, cyc, o_fi, fi);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            e_cp[i] = 0; e_cl[i] = 0; e_bp[i] = 0; e_bi[i] = 0;
            e_pl[i] = 0; e_pa[i] = 0; e_fi[i] = 0;
            s_start[i] = 1'b0; s_pause[i] = 1'b0; s_abort[i] = 1'b0;
        end
        cut = N;
    endtask

    // Cycle in which song beat k strobes, for a start sampled at edge s.
    function automatic int beat_cyc(input int bd, input int ci, input int s,
                                    input int k, input int p, input int len);
        return s + bd * (ci + k + 1) + 1 + ((k >= p) ? len + 1 : 0);
    endfunction

    // Fill expectations for a song started at edge s, valid up to cycle lim.
    // p is the beat whose tick is hit by a pause (p >= sb: no pause), len the
    // number of edges until the resuming pause.
    task automatic model_song(input int bd, input int sb, input int ci, input int s,
                              input int lim, input int p, input int len);
        int play_c, last_c, ep, cnt, bk;
        play_c = s + bd * ci + 1;
        last_c = beat_cyc(bd, ci, s, sb - 1, p, len);
        ep     = s + bd * (ci + p + 1);
        for (int c = s + 1; c <= lim && c < N; c++) begin
            cnt = 0;
            e_cp[c] = 0;
            for (int j = 1; j <= ci; j++) begin
                if (s + bd * j + 1 <= c) cnt++;
                if (s + bd * j + 1 == c) e_cp[c] = 1;
            end
            e_cl[c] = ci - cnt;
            e_bp[c] = 0;
            e_bi[c] = 0;
            for (int k = 0; k < sb; k++) begin
                bk = beat_cyc(bd, ci, s, k, p, len);
                if (bk <= c) e_bi[c] = k;
                if (bk == c) e_bp[c] = 1;
            end
            e_pa[c] = (p < sb && c > ep && c <= ep + len) ? 1 : 0;
            e_pl[c] = (c >= play_c && c < last_c && e_pa[c] == 0) ? 1 : 0;
            e_fi[c] = (c >= last_c) ? 1 : 0;
        end
    endtask

    // Schedule an input pulse unless it falls at or after the abort cut.
    task automatic sched(input int e, input int which);
        if (e >= 0 && e < cut && e < N) begin
            case (which)
                0: s_start[e] = 1'b1;
                1: s_pause[e] = 1'b1;
                default: s_abort[e] = 1'b1;
            endcase
        end
    endtask

    // Drive scheduled inputs for edges 0..ncyc-1, check cycles 1..ncyc.
    task automatic run(input bit sel, input int ncyc);
        beats_seen = 0;
        for (int c = 1; c <= ncyc && c < N; c++) begin
            if (sel) begin
                b_start = s_start[c-1]; b_pause = s_pause[c-1]; b_abort = s_abort[c-1];
            end else begin
                a_start = s_start[c-1]; a_pause = s_pause[c-1]; a_abort = s_abort[c-1];
            end
            @(posedge clk); #1;
            check_vals(sel, c, e_cp[c], e_cl[c], e_bp[c], e_bi[c], e_pl[c], e_pa[c], e_fi[c]);
        end
        a_start = 1'b0; a_pause = 1'b0; a_abort = 1'b0;
        b_start = 1'b0; b_pause = 1'b0; b_abort = 1'b0;
    endtask

    task automatic go_idle(input bit sel);
        if (sel) b_abort = 1'b1; else a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0; b_abort = 1'b0;
        check_vals(sel, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int s, p, len, ep, pc, ig, pd, last_c, a, s2, play_c;
        bit do_abort;

        rst = 1'b1;
        a_start = 1'b0; a_pause = 1'b0; a_abort = 1'b0;
        b_start = 1'b0; b_pause = 1'b0; b_abort = 1'b0;

        // Reset held two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            a_start = 1'($urandom); a_pause = 1'($urandom); a_abort = 1'($urandom);
            b_start = 1'($urandom); b_pause = 1'($urandom); b_abort = 1'($urandom);
            @(posedge clk); #1;
            check_vals(1'b0, i, 0, 0, 0, 0, 0, 0, 0);
            check_vals(1'b1, i, 0, 0, 0, 0, 0, 0, 0);
        end
        rst = 1'b0;
        a_start = 1'b0; a_pause = 1'b0; a_abort = 1'b0;
        b_start = 1'b0; b_pause = 1'b0; b_abort = 1'b0;

        // Pause and abort pulses in IDLE do nothing.
        clear_all();
        s_pause[1] = 1'b1; s_abort[3] = 1'b1;
        run(1'b0, 6);

        // Full song.
        clear_all();
        s_start[0] = 1'b1;
        model_song(BD, SB, CI, 0, N - 1, SB, 0);
        run(1'b0, 45);
        check("beat_count_full", 1'b0, 45, 32'(beats_seen), 8);

        // Pause on a beat tick, resume 10 edges later.
        go_idle(1'b0);
        clear_all();
        s_start[0] = 1'b1; s_pause[20] = 1'b1; s_pause[30] = 1'b1;
        model_song(BD, SB, CI, 0, N - 1, 2, 10);
        run(1'b0, 56);
        check("beat_count_pause", 1'b0, 56, 32'(beats_seen), 8);

        // Abort mid-song, then a fresh start.
        go_idle(1'b0);
        clear_all();
        s_start[0] = 1'b1; s_abort[18] = 1'b1; s_start[25] = 1'b1;
        model_song(BD, SB, CI, 0, 18, SB, 0);
        model_song(BD, SB, CI, 25, N - 1, SB, 0);
        run(1'b0, 70);

        // Start during PLAY ignored; start in DONE restarts.
        go_idle(1'b0);
        clear_all();
        s_start[0] = 1'b1; s_start[24] = 1'b1; s_start[45] = 1'b1;
        model_song(BD, SB, CI, 0, 45, SB, 0);
        model_song(BD, SB, CI, 45, N - 1, SB, 0);
        run(1'b0, 90);
        check("beat_count_restart", 1'b0, 90, 32'(beats_seen), 16);

        // Randomized sessions: pause length/position, ignored inputs, abort or restart.
        for (int it = 0; it < 8; it++) begin
            go_idle(1'b0);
            clear_all();
            s        = $urandom_range(0, 5);
            p        = $urandom_range(0, SB - 1);
            len      = $urandom_range(1, 6);
            do_abort = 1'($urandom_range(0, 1));
            play_c   = s + BD * CI + 1;
            ep       = s + BD * (CI + p + 1);
            last_c   = beat_cyc(BD, CI, s, SB - 1, p, len);
            pc       = $urandom_range(s + 1, s + BD * CI);
            ig       = $urandom_range(play_c, last_c - 1);
            if (do_abort) begin
                a   = $urandom_range(s + 1, last_c + 3);
                s2  = a + $urandom_range(1, 4);
                cut = a;
            end else begin
                a   = -1;
                pd  = $urandom_range(last_c, last_c + 2);
                s2  = pd + $urandom_range(1, 3);
            end
            s_start[s] = 1'b1;
            sched(pc, 1);
            sched(ep, 1);
            sched(ep + len, 1);
            sched(ig, 0);
            if (do_abort) s_abort[a] = 1'b1;
            else sched(pd, 1);
            s_start[s2] = 1'b1;
            model_song(BD, SB, CI, s, do_abort ? a : s2, p, len);
            model_song(BD, SB, CI, s2, N - 1, SB, 0);
            run(1'b0, s2 + 44);
        end

        // No count-in, single-beat song, then restart from DONE.
        go_idle(1'b1);
        clear_all();
        s_start[0] = 1'b1; s_start[7] = 1'b1;
        model_song(4, 1, 0, 0, 7, 1, 0);
        model_song(4, 1, 0, 7, N - 1, 1, 0);
        run(1'b1, 14);
        check("beat_count_single", 1'b1, 14, 32'(beats_seen), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
